// File: rtl/pcie_seq_pkg.sv
// Shared types and constants for the PCIe PERST_n / REFCLK sequencer.
// Holds the state encoding and the output widths used by the top and the bench.
package pcie_seq_pkg;

    localparam int SEQ_STATE_W   = 3;
    localparam int RESET_COUNT_W = 8;
    localparam int CNT_W_DEFAULT = 16;

    // Encodings are visible on SEQ_STATE, so they must not be reordered.
    typedef enum logic [SEQ_STATE_W-1:0] {
        ST_OFF      = 3'd0,
        ST_PWR_STAB = 3'd1,
        ST_TRAIN    = 3'd2,
        ST_UP       = 3'd3,
        ST_WARM     = 3'd4,
        ST_FAIL     = 3'd5
    } seq_state_e;

    function automatic logic [RESET_COUNT_W-1:0] sat_inc(input logic [RESET_COUNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pcie_seq_timer.sv
// Clearable, enableable up-counter with a terminal compare.
// Saturates at all-ones instead of wrapping; clear has priority over enable.
module pcie_seq_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             at_term
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign at_term = (count == term);

endmodule

// File: rtl/pcie_perst_sequencer.sv
// Upstream PCIe reset sequencer: drives PERST_n and REFCLK_EN, supervises link-up.
// Optional feature macro PCIE_PERST_SEQ_AUTO_RETRY_EN turns link-up timeouts into warm-reset retries.
module pcie_perst_sequencer
    import pcie_seq_pkg::*;
#(
    parameter int T_PVPERL       = 100,
    parameter int T_PERST_MIN    = 16,
    parameter int LINKUP_TIMEOUT = 1000,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = CNT_W_DEFAULT
) (
    input  logic                     CLK,
    input  logic                     RST_n,
    input  logic                     PWR_GOOD,
    input  logic                     REFCLK_STABLE,
    input  logic                     SW_RESET_REQ,
    input  logic                     LINK_UP,
    output logic                     PERST_n,
    output logic                     REFCLK_EN,
    output logic [SEQ_STATE_W-1:0]   SEQ_STATE,
    output logic                     LINK_TIMEOUT,
    output logic                     LINK_DOWN_EVT,
    output logic [RESET_COUNT_W-1:0] RESET_COUNT
);

    // SW_RESET_REQ is a one-cycle request pulse with no acknowledge; it is
    // sampled on a single edge and dropped silently in OFF, PWR_STAB and WARM.

    seq_state_e       state, next_state;
    logic             timer_clr, timer_en, timer_at_term;
    logic [CNT_W-1:0] timer_term;
    logic             timeout_hit, link_down, retry_inc, retry_clr, retry_ok;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state <= ST_OFF;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state  = state;
        timer_en    = 1'b0;
        timer_term  = '1;
        timeout_hit = 1'b0;
        link_down   = 1'b0;
        retry_inc   = 1'b0;
        retry_clr   = 1'b0;
        case (state)
            ST_OFF: begin
                if (PWR_GOOD) next_state = ST_PWR_STAB;
            end
            ST_PWR_STAB: begin
                timer_en   = REFCLK_STABLE;
                timer_term = CNT_W'(T_PVPERL - 1);
                if (!PWR_GOOD)                          next_state = ST_OFF;
                else if (REFCLK_STABLE && timer_at_term) next_state = ST_TRAIN;
            end
            ST_TRAIN: begin
                timer_en   = 1'b1;
                timer_term = CNT_W'(LINKUP_TIMEOUT - 1);
                if (!PWR_GOOD) begin
                    next_state = ST_OFF;
                end else if (SW_RESET_REQ) begin
                    next_state = ST_WARM;
                    retry_clr  = 1'b1;
                end else if (LINK_UP) begin
                    next_state = ST_UP;
                    retry_clr  = 1'b1;
                end else if (timer_at_term) begin
                    timeout_hit = 1'b1;
                    if (retry_ok) begin
                        next_state = ST_WARM;
                        retry_inc  = 1'b1;
                    end else begin
                        next_state = ST_FAIL;
                    end
                end
            end
            ST_UP: begin
                if (!PWR_GOOD) begin
                    next_state = ST_OFF;
                end else if (SW_RESET_REQ) begin
                    next_state = ST_WARM;
                    retry_clr  = 1'b1;
                end else if (!LINK_UP) begin
                    next_state = ST_TRAIN;
                    link_down  = 1'b1;
                end
            end
            ST_WARM: begin
                timer_en   = 1'b1;
                timer_term = CNT_W'(T_PERST_MIN - 1);
                if (!PWR_GOOD)          next_state = ST_OFF;
                else if (timer_at_term) next_state = ST_TRAIN;
            end
            ST_FAIL: begin
                if (!PWR_GOOD) begin
                    next_state = ST_OFF;
                end else if (SW_RESET_REQ) begin
                    next_state = ST_WARM;
                    retry_clr  = 1'b1;
                end
            end
            default: next_state = ST_OFF;
        endcase
    end

    // A glitch on REFCLK_STABLE restarts the power-stable window from zero.
    assign timer_clr = (next_state != state) || ((state == ST_PWR_STAB) && !REFCLK_STABLE);

    pcie_seq_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (CLK),
        .rst_n   (RST_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .term    (timer_term),
        .at_term (timer_at_term)
    );

`ifdef PCIE_PERST_SEQ_AUTO_RETRY_EN
    localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    logic [RETRY_W-1:0] retry_cnt;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            retry_cnt <= '0;
        end else if (retry_clr || (next_state == ST_OFF)) begin
            retry_cnt <= '0;
        end else if (retry_inc) begin
            retry_cnt <= retry_cnt + 1'b1;
        end
    end

    assign retry_ok = (int'(retry_cnt) < MAX_RETRY);
`else
    logic unused_retry;

    assign retry_ok     = 1'b0;
    assign unused_retry = ^{retry_inc, retry_clr, 32'(MAX_RETRY)};
`endif

    // Outputs are computed from next_state so they change on the entry edge.
    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            PERST_n       <= 1'b0;
            REFCLK_EN     <= 1'b0;
            LINK_TIMEOUT  <= 1'b0;
            LINK_DOWN_EVT <= 1'b0;
            RESET_COUNT   <= '0;
        end else begin
            PERST_n       <= (next_state == ST_TRAIN) || (next_state == ST_UP) ||
                             (next_state == ST_FAIL);
            REFCLK_EN     <= (next_state != ST_OFF);
            LINK_DOWN_EVT <= link_down;
            if (next_state == ST_OFF) begin
                LINK_TIMEOUT <= 1'b0;
            end else if (timeout_hit) begin
                LINK_TIMEOUT <= 1'b1;
            end
            if ((next_state == ST_WARM) && (state != ST_WARM)) begin
                RESET_COUNT <= sat_inc(RESET_COUNT);
            end
        end
    end

    assign SEQ_STATE = state;

endmodule

// File: tb/tb_pcie_perst_sequencer.sv
// Directed bench for pcie_perst_sequencer with T_PVPERL=10, T_PERST_MIN=4, LINKUP_TIMEOUT=20.
// Honours PCIE_PERST_SEQ_AUTO_RETRY_EN for the timeout expectations.
module tb_pcie_perst_sequencer;

    logic       CLK;
    logic       RST_n;
    logic       PWR_GOOD;
    logic       REFCLK_STABLE;
    logic       SW_RESET_REQ;
    logic       LINK_UP;
    logic       PERST_n;
    logic       REFCLK_EN;
    logic [2:0] SEQ_STATE;
    logic       LINK_TIMEOUT;
    logic       LINK_DOWN_EVT;
    logic [7:0] RESET_COUNT;

    int n_checks = 0;
    int n_errors = 0;
    int rc       = 0;

    logic [7:0] exp_q[$];
    logic [7:0] prev_rc = 8'd0;

    pcie_perst_sequencer #(
        .T_PVPERL       (10),
        .T_PERST_MIN    (4),
        .LINKUP_TIMEOUT (20),
        .MAX_RETRY      (3),
        .CNT_W          (16)
    ) dut (
        .CLK           (CLK),
        .RST_n         (RST_n),
        .PWR_GOOD      (PWR_GOOD),
        .REFCLK_STABLE (REFCLK_STABLE),
        .SW_RESET_REQ  (SW_RESET_REQ),
        .LINK_UP       (LINK_UP),
        .PERST_n       (PERST_n),
        .REFCLK_EN     (REFCLK_EN),
        .SEQ_STATE     (SEQ_STATE),
        .LINK_TIMEOUT  (LINK_TIMEOUT),
        .LINK_DOWN_EVT (LINK_DOWN_EVT),
        .RESET_COUNT   (RESET_COUNT)
    );

    // Clock and watchdog
    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance n active edges, then settle 1ns past the edge for drive and sample.
    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic expect_warm_entry();
        rc = (rc < 255) ? rc + 1 : rc;
        exp_q.push_back(8'(rc));
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_state"}, 32'(SEQ_STATE), 32'd0);
        check_eq({tag, "_perst"}, 32'(PERST_n), 32'd0);
        check_eq({tag, "_refclk_en"}, 32'(REFCLK_EN), 32'd0);
        check_eq({tag, "_timeout"}, 32'(LINK_TIMEOUT), 32'd0);
        check_eq({tag, "_down_evt"}, 32'(LINK_DOWN_EVT), 32'd0);
        check_eq({tag, "_rst_cnt"}, 32'(RESET_COUNT), 32'd0);
    endtask

    // Scoreboard: every RESET_COUNT change must match the next queued value.
    always @(negedge CLK) begin
        if (!RST_n) begin
            prev_rc = RESET_COUNT;
        end else if (RESET_COUNT !== prev_rc) begin
            if (exp_q.size() == 0) check_eq("rc_unexpected", 32'(RESET_COUNT), 32'(prev_rc));
            else                   check_eq("rc_seq", 32'(RESET_COUNT), 32'(exp_q.pop_front()));
            prev_rc = RESET_COUNT;
        end
    end

    initial begin
        RST_n         = 1'b0;
        PWR_GOOD      = 1'b0;
        REFCLK_STABLE = 1'b0;
        SW_RESET_REQ  = 1'b0;
        LINK_UP       = 1'b0;
        tick(2);
        check_reset_values("reset");
        RST_n = 1'b1;
        tick(1);
        check_eq("off_idle_state", 32'(SEQ_STATE), 32'd0);

        // Cold boot
        PWR_GOOD      = 1'b1;
        REFCLK_STABLE = 1'b1;
        tick(1);
        check_eq("boot_pwr_stab", 32'(SEQ_STATE), 32'd1);
        check_eq("boot_refclk_en", 32'(REFCLK_EN), 32'd1);
        check_eq("boot_perst_low", 32'(PERST_n), 32'd0);
        tick(9);
        check_eq("boot_perst_hold9", 32'(PERST_n), 32'd0);
        tick(1);
        check_eq("boot_perst_rise", 32'(PERST_n), 32'd1);
        check_eq("boot_train", 32'(SEQ_STATE), 32'd2);
        tick(5);
        LINK_UP = 1'b1;
        tick(1);
        check_eq("boot_up", 32'(SEQ_STATE), 32'd3);
        check_eq("boot_no_timeout", 32'(LINK_TIMEOUT), 32'd0);

        // Link drop, then no link-up: timeout path
        LINK_UP = 1'b0;
        tick(1);
        check_eq("drop_train", 32'(SEQ_STATE), 32'd2);
        check_eq("drop_evt", 32'(LINK_DOWN_EVT), 32'd1);
        check_eq("drop_perst", 32'(PERST_n), 32'd1);
        tick(1);
        check_eq("drop_evt_clear", 32'(LINK_DOWN_EVT), 32'd0);
`ifdef PCIE_PERST_SEQ_AUTO_RETRY_EN
        for (int r = 0; r < 3; r++) begin
            tick(18);
            check_eq("retry_still_train", 32'(SEQ_STATE), 32'd2);
            expect_warm_entry();
            tick(1);
            check_eq("retry_warm", 32'(SEQ_STATE), 32'd4);
            check_eq("retry_perst_low", 32'(PERST_n), 32'd0);
            check_eq("retry_timeout_flag", 32'(LINK_TIMEOUT), 32'd1);
            tick(3);
            check_eq("retry_perst_hold", 32'(PERST_n), 32'd0);
            tick(1);
            check_eq("retry_back_train", 32'(SEQ_STATE), 32'd2);
            tick(1);
        end
`endif
        tick(18);
        check_eq("to_still_train", 32'(SEQ_STATE), 32'd2);
        check_eq("to_flag_pre", 32'(LINK_TIMEOUT), ((rc > 0) ? 32'd1 : 32'd0));
        tick(1);
        check_eq("to_fail", 32'(SEQ_STATE), 32'd5);
        check_eq("to_flag", 32'(LINK_TIMEOUT), 32'd1);
        check_eq("to_perst", 32'(PERST_n), 32'd1);
        check_eq("to_rst_cnt", 32'(RESET_COUNT), 32'(rc));
        tick(3);
        check_eq("fail_sticky", 32'(SEQ_STATE), 32'd5);

        // SW reset out of FAIL; a second request inside WARM is ignored
        SW_RESET_REQ = 1'b1;
        expect_warm_entry();
        tick(1);
        SW_RESET_REQ = 1'b0;
        LINK_UP      = 1'b1;
        check_eq("fail_sw_warm", 32'(SEQ_STATE), 32'd4);
        check_eq("fail_sw_rst_cnt", 32'(RESET_COUNT), 32'(rc));
        check_eq("fail_sw_flag_kept", 32'(LINK_TIMEOUT), 32'd1);
        tick(1);
        SW_RESET_REQ = 1'b1;
        tick(1);
        SW_RESET_REQ = 1'b0;
        tick(1);
        check_eq("warm_ignore_perst", 32'(PERST_n), 32'd0);
        tick(1);
        check_eq("warm_ignore_train", 32'(SEQ_STATE), 32'd2);
        check_eq("warm_ignore_rst_cnt", 32'(RESET_COUNT), 32'(rc));
        tick(1);
        check_eq("warm_ignore_up", 32'(SEQ_STATE), 32'd3);

        // Warm reset from UP: PERST_n low exactly four cycles
        SW_RESET_REQ = 1'b1;
        expect_warm_entry();
        tick(1);
        SW_RESET_REQ = 1'b0;
        check_eq("warm_state", 32'(SEQ_STATE), 32'd4);
        check_eq("warm_perst", 32'(PERST_n), 32'd0);
        check_eq("warm_refclk_en", 32'(REFCLK_EN), 32'd1);
        check_eq("warm_rst_cnt", 32'(RESET_COUNT), 32'(rc));
        tick(3);
        check_eq("warm_perst_last", 32'(PERST_n), 32'd0);
        tick(1);
        check_eq("warm_perst_rise", 32'(PERST_n), 32'd1);
        check_eq("warm_train", 32'(SEQ_STATE), 32'd2);
        tick(1);
        check_eq("warm_up", 32'(SEQ_STATE), 32'd3);

        // LINK_UP arriving on the timeout cycle wins
        LINK_UP = 1'b0;
        tick(1);
        check_eq("win_train", 32'(SEQ_STATE), 32'd2);
        tick(19);
        check_eq("win_pre_state", 32'(SEQ_STATE), 32'd2);
        LINK_UP = 1'b1;
        tick(1);
        check_eq("win_linkup", 32'(SEQ_STATE), 32'd3);

        // PWR_GOOD drop collides with SW_RESET_REQ
        PWR_GOOD     = 1'b0;
        SW_RESET_REQ = 1'b1;
        tick(1);
        SW_RESET_REQ = 1'b0;
        LINK_UP      = 1'b0;
        check_eq("coll_state", 32'(SEQ_STATE), 32'd0);
        check_eq("coll_perst", 32'(PERST_n), 32'd0);
        check_eq("coll_refclk_en", 32'(REFCLK_EN), 32'd0);
        check_eq("coll_timeout_clr", 32'(LINK_TIMEOUT), 32'd0);
        check_eq("coll_rst_cnt", 32'(RESET_COUNT), 32'(rc));

        // Reference clock glitch at count 7
        PWR_GOOD = 1'b1;
        tick(1);
        check_eq("glitch_pwr_stab", 32'(SEQ_STATE), 32'd1);
        tick(7);
        REFCLK_STABLE = 1'b0;
        tick(1);
        REFCLK_STABLE = 1'b1;
        check_eq("glitch_hold_state", 32'(SEQ_STATE), 32'd1);
        tick(2);
        check_eq("glitch_no_early", 32'(PERST_n), 32'd0);
        tick(7);
        check_eq("glitch_perst_hold", 32'(PERST_n), 32'd0);
        tick(1);
        check_eq("glitch_perst_rise", 32'(PERST_n), 32'd1);
        check_eq("glitch_train", 32'(SEQ_STATE), 32'd2);

        // Asynchronous reset in the middle of WARM
        LINK_UP = 1'b1;
        tick(1);
        check_eq("pre_async_up", 32'(SEQ_STATE), 32'd3);
        SW_RESET_REQ = 1'b1;
        expect_warm_entry();
        tick(1);
        SW_RESET_REQ = 1'b0;
        check_eq("pre_async_warm", 32'(SEQ_STATE), 32'd4);
        tick(1);
        #2;
        RST_n = 1'b0;
        #1;
        check_reset_values("async");
        rc = 0;
        tick(1);
        RST_n = 1'b1;
        tick(1);
        check_eq("reboot_pwr_stab", 32'(SEQ_STATE), 32'd1);
        check_eq("reboot_refclk_en", 32'(REFCLK_EN), 32'd1);
        tick(9);
        check_eq("reboot_perst_hold", 32'(PERST_n), 32'd0);
        tick(1);
        check_eq("reboot_perst_rise", 32'(PERST_n), 32'd1);
        check_eq("reboot_train", 32'(SEQ_STATE), 32'd2);

        tick(1);
        check_eq("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
